// File: rtl/data_sram_responder.sv
// Data-side SRAM-like slave: word-array backed, in-order pipelined responses
// with configurable address-accept and response latency for stall stressing.
module data_sram_responder #(
   parameter int AW       = 10,
   parameter int ADDR_LAT = 0,
   parameter int DATA_LAT = 1,
   parameter int DEPTH    = 2
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);

   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNTW = $clog2(DEPTH + 1);
   localparam int DW   = (DATA_LAT > 1) ? $clog2(DATA_LAT) : 1;
   localparam int WW   = (ADDR_LAT > 0) ? $clog2(ADDR_LAT + 1) : 1;
   localparam logic [DW-1:0] CD_INIT = DW'(DATA_LAT - 1);

   if (DATA_LAT < 1) begin : g_bad_data_lat
      $error("data_sram_responder: DATA_LAT must be at least 1");
   end

   logic [31:0]     mem     [2**AW];
   logic [31:0]     q_rdata [DEPTH];
   logic [DW-1:0]   q_cd    [DEPTH];
   logic [PW-1:0]   head, tail;
   logic [CNTW-1:0] count;
   logic [WW-1:0]   wait_cnt;
   logic [AW-1:0]   idx;
   logic            lat_ok, accept, pop;
   logic            unused_ok;

   // Size and the sub-word / aliased address bits carry no meaning here.
   assign unused_ok = ^{data_sram_size, data_sram_addr[1:0], data_sram_addr[31:AW+2]};

   function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign idx = data_sram_addr[AW+1:2];

   if (ADDR_LAT == 0) begin : g_no_addr_lat
      assign wait_cnt = '0;
      assign lat_ok   = 1'b1;
   end else begin : g_addr_lat
      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn)
            wait_cnt <= '0;
         else if (!data_sram_req || accept)
            wait_cnt <= '0;
         else if (wait_cnt < WW'(ADDR_LAT))
            wait_cnt <= wait_cnt + 1'b1;
      end
      assign lat_ok = (wait_cnt >= WW'(ADDR_LAT));
   end

   // A full queue never accepts, even while the head is popping this cycle.
   assign data_sram_addr_ok = resetn && (count < CNTW'(DEPTH)) && lat_ok;
   assign accept            = data_sram_req && data_sram_addr_ok;
   assign data_sram_data_ok = (count != '0) && (q_cd[head] == '0);
   assign data_sram_rdata   = data_sram_data_ok ? q_rdata[head] : '0;
   assign pop               = data_sram_data_ok;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         if (accept) tail <= inc_ptr(tail);
         if (pop)    head <= inc_ptr(head);
         case ({accept, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: the array and queue payload carry no reset; validity lives in count.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++)
         if (q_cd[i] != '0) q_cd[i] <= q_cd[i] - 1'b1;
      if (accept) begin
         q_cd[tail]    <= CD_INIT;
         q_rdata[tail] <= data_sram_wr ? '0 : mem[idx];
      end
   end

   always_ff @(posedge clk) begin
      if (accept && data_sram_wr)
         for (int b = 0; b < 4; b++)
            if (data_sram_wstrb[b]) mem[idx][8*b +: 8] <= data_sram_wdata[8*b +: 8];
   end

   // The master must hold a pending request unchanged until it is accepted.
   property p_req_hold;
      @(posedge clk) disable iff (!resetn)
         (data_sram_req && !data_sram_addr_ok) |=>
            (data_sram_req && $stable({data_sram_wr, data_sram_size, data_sram_wstrb,
                                       data_sram_addr, data_sram_wdata}));
   endproperty
   a_req_hold: assert property (p_req_hold);

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances cover zero/extra
// address latency, single/multi-cycle response latency and a full queue.
module tb_data_sram_responder;

   logic        clk    = 1'b0;
   logic        resetn = 1'b0;
   logic [2:0]  req    = '0;
   logic        wr     = 1'b0;
   logic [1:0]  size   = 2'd2;
   logic [3:0]  wstrb  = '0;
   logic [31:0] addr   = '0;
   logic [31:0] wdata  = '0;
   wire  [2:0]  aok, dok;
   wire  [31:0] rd0, rd1, rd2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   data_sram_responder #(.AW(10), .ADDR_LAT(0), .DATA_LAT(1), .DEPTH(2)) u_dut0 (
      .clk(clk), .resetn(resetn), .data_sram_req(req[0]), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
      .data_sram_rdata(rd0));

   data_sram_responder #(.AW(10), .ADDR_LAT(0), .DATA_LAT(3), .DEPTH(2)) u_dut1 (
      .clk(clk), .resetn(resetn), .data_sram_req(req[1]), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
      .data_sram_rdata(rd1));

   data_sram_responder #(.AW(10), .ADDR_LAT(2), .DATA_LAT(1), .DEPTH(2)) u_dut2 (
      .clk(clk), .resetn(resetn), .data_sram_req(req[2]), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_addr_ok(aok[2]), .data_sram_data_ok(dok[2]),
      .data_sram_rdata(rd2));

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[12];

   function automatic logic [31:0] rd_of(input int sel);
      case (sel)
         0:       return rd0;
         1:       return rd1;
         default: return rd2;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts just after a negedge; returns data and the number of cycles from
   // the accept edge to the cycle in which data_ok was seen.
   task automatic run_xact(input int sel, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s,
                           output logic [31:0] rdata, output int lat);
      bit got;
      rdata = '0;
      lat   = 0;
      wr = w; addr = a; wdata = d; wstrb = s;
      req[sel] = 1'b1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (aok[sel]) got = 1'b1;
         else @(negedge clk);
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL addr_ok_timeout dut%0d: no accept for addr %h", sel, a);
         req[sel] = 1'b0;
         return;
      end
      @(negedge clk);
      req[sel] = 1'b0;
      lat = 1;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         #1;
         if (dok[sel]) begin
            got   = 1'b1;
            rdata = rd_of(sel);
         end else begin
            @(negedge clk);
            lat++;
         end
      end
      if (!got) begin
         n_checks++; n_fail++;
         $display("FAIL data_ok_timeout dut%0d: no response for addr %h", sel, a);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      int          lat;

      vecs[0]  = '{1'b1, 32'h0000_01C0, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000};
      vecs[1]  = '{1'b0, 32'h0000_01C0, 32'h0000_0000, 4'h0, 32'hDEAD_BEEF};
      vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1122_3344, 4'hF, 32'h0000_0000};
      vecs[3]  = '{1'b1, 32'h0000_0040, 32'h0000_00AA, 4'h1, 32'h0000_0000};
      vecs[4]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'h1122_33AA};
      vecs[5]  = '{1'b1, 32'h0000_0080, 32'h0000_0005, 4'hF, 32'h0000_0000};
      vecs[6]  = '{1'b1, 32'h0000_1044, 32'hCAFE_F00D, 4'hF, 32'h0000_0000};
      vecs[7]  = '{1'b0, 32'h0000_0046, 32'h0000_0000, 4'h0, 32'hCAFE_F00D};
      vecs[8]  = '{1'b1, 32'h0000_0040, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000};
      vecs[9]  = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'h1122_33AA};
      vecs[10] = '{1'b1, 32'h0000_0042, 32'h5566_7788, 4'hC, 32'h0000_0000};
      vecs[11] = '{1'b0, 32'h0000_0040, 32'h0000_0000, 4'h0, 32'h5566_33AA};

      // Reset state
      #2;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst_addr_ok%0d", s), 32'(aok[s]), 32'd0);
         check($sformatf("rst_data_ok%0d", s), 32'(dok[s]), 32'd0);
         check($sformatf("rst_rdata%0d", s), rd_of(s), 32'd0);
      end
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      @(negedge clk);

      // Single transactions, ADDR_LAT=0 / DATA_LAT=1
      foreach (vecs[v]) begin
         run_xact(0, vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, r, lat);
         check($sformatf("vec%0d_rdata", v), r, vecs[v].exp);
         check($sformatf("vec%0d_lat", v), 32'(lat), 32'd1);
      end

      // Read then write of the same word: read keeps the old value
      @(negedge clk);
      wr = 1'b0; addr = 32'h80; req[0] = 1'b1;
      #1 check("ord_accept_rd", 32'(aok[0]), 32'd1);
      @(negedge clk);
      wr = 1'b1; wdata = 32'h9; wstrb = 4'hF;
      #1;
      check("ord_rd_data_ok", 32'(dok[0]), 32'd1);
      check("ord_rd_rdata", rd0, 32'h5);
      check("ord_accept_wr", 32'(aok[0]), 32'd1);
      @(negedge clk);
      req[0] = 1'b0;
      #1;
      check("ord_wr_data_ok", 32'(dok[0]), 32'd1);
      check("ord_wr_rdata", rd0, 32'h0);
      @(negedge clk);
      run_xact(0, 1'b0, 32'h80, 32'h0, 4'h0, r, lat);
      check("ord_reread", r, 32'h9);

      // Fill memory through the DATA_LAT=3 instance
      @(negedge clk);
      run_xact(1, 1'b1, 32'h100, 32'hA1A1_A1A1, 4'hF, r, lat);
      check("dl3_wr_lat", 32'(lat), 32'd3);
      check("dl3_wr_rdata", r, 32'h0);
      @(negedge clk);
      run_xact(1, 1'b1, 32'h104, 32'hB2B2_B2B2, 4'hF, r, lat);
      @(negedge clk);
      run_xact(1, 1'b1, 32'h108, 32'hC3C3_C3C3, 4'hF, r, lat);
      @(negedge clk);

      // Back-to-back reads into a full queue
      @(negedge clk);
      wr = 1'b0; addr = 32'h100; req[1] = 1'b1;
      #1 check("b2b_c0_addr_ok", 32'(aok[1]), 32'd1);
      @(negedge clk);
      addr = 32'h104;
      #1;
      check("b2b_c1_addr_ok", 32'(aok[1]), 32'd1);
      check("b2b_c1_data_ok", 32'(dok[1]), 32'd0);
      @(negedge clk);
      addr = 32'h108;
      #1;
      check("b2b_c2_full", 32'(aok[1]), 32'd0);
      check("b2b_c2_data_ok", 32'(dok[1]), 32'd0);
      @(negedge clk);
      #1;
      check("b2b_c3_no_passthru", 32'(aok[1]), 32'd0);
      check("b2b_c3_data_ok", 32'(dok[1]), 32'd1);
      check("b2b_c3_rdata", rd1, 32'hA1A1_A1A1);
      @(negedge clk);
      #1;
      check("b2b_c4_addr_ok", 32'(aok[1]), 32'd1);
      check("b2b_c4_data_ok", 32'(dok[1]), 32'd1);
      check("b2b_c4_rdata", rd1, 32'hB2B2_B2B2);
      @(negedge clk);
      req[1] = 1'b0;
      #1 check("b2b_c5_data_ok", 32'(dok[1]), 32'd0);
      @(negedge clk);
      #1 check("b2b_c6_data_ok", 32'(dok[1]), 32'd0);
      @(negedge clk);
      #1;
      check("b2b_c7_data_ok", 32'(dok[1]), 32'd1);
      check("b2b_c7_rdata", rd1, 32'hC3C3_C3C3);
      @(negedge clk);
      #1 check("b2b_c8_data_ok", 32'(dok[1]), 32'd0);

      // Reset with two responses pending
      @(negedge clk);
      wr = 1'b0; addr = 32'h100; req[1] = 1'b1;
      @(negedge clk);
      addr = 32'h104;
      @(negedge clk);
      req[1] = 1'b0;
      @(negedge clk);
      #1;
      check("rst_pre_data_ok", 32'(dok[1]), 32'd1);
      check("rst_pre_rdata", rd1, 32'hA1A1_A1A1);
      #1 resetn = 1'b0;
      #1;
      check("rst_mid_data_ok", 32'(dok[1]), 32'd0);
      check("rst_mid_addr_ok", 32'(aok[1]), 32'd0);
      check("rst_mid_rdata", rd1, 32'd0);
      check("rst_mid_addr_ok0", 32'(aok[0]), 32'd0);
      @(negedge clk);
      @(negedge clk);
      resetn = 1'b1;
      for (int c = 0; c < 6; c++) begin
         #1 check($sformatf("rst_stale_c%0d", c), 32'(dok[1]), 32'd0);
         @(negedge clk);
      end
      run_xact(1, 1'b0, 32'h104, 32'h0, 4'h0, r, lat);
      check("rst_mem_kept", r, 32'hB2B2_B2B2);
      check("rst_mem_lat", 32'(lat), 32'd3);

      // ADDR_LAT=2: accept only after two waiting cycles, then counter restarts
      @(negedge clk);
      @(negedge clk);
      wr = 1'b1; addr = 32'h200; wdata = 32'h77; wstrb = 4'hF; req[2] = 1'b1;
      #1 check("al2_k0_addr_ok", 32'(aok[2]), 32'd0);
      @(negedge clk);
      #1 check("al2_k1_addr_ok", 32'(aok[2]), 32'd0);
      @(negedge clk);
      #1 check("al2_k2_addr_ok", 32'(aok[2]), 32'd1);
      @(negedge clk);
      wr = 1'b0;
      #1;
      check("al2_k3_addr_ok", 32'(aok[2]), 32'd0);
      check("al2_k3_data_ok", 32'(dok[2]), 32'd1);
      check("al2_k3_rdata", rd2, 32'd0);
      @(negedge clk);
      #1 check("al2_k4_addr_ok", 32'(aok[2]), 32'd0);
      @(negedge clk);
      #1 check("al2_k5_addr_ok", 32'(aok[2]), 32'd1);
      @(negedge clk);
      req[2] = 1'b0;
      #1;
      check("al2_k6_data_ok", 32'(dok[2]), 32'd1);
      check("al2_k6_rdata", rd2, 32'h77);
      check("al2_k6_addr_ok", 32'(aok[2]), 32'd0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Slave end of the data-side SRAM-like request/response interface. The EXE stage issues requests; the MEM stage consumes data_ok/rdata.
- Backed by an internal word array; accepts pipelined requests and returns responses in order.
- Address-accept and response latency are configurable, so the pipeline stages can be stressed with stalls in simulation and on FPGA.

Parameters:
- AW, 10, log2 of memory depth in 32-bit words (1024 words).
- ADDR_LAT, 0, cycles req must be held before addr_ok rises (0 = same cycle).
- DATA_LAT, 1, cycles from acceptance to data_ok (minimum 1).
- DEPTH, 2, maximum outstanding (accepted, unanswered) requests; power of two.

Ports:
- clk  in  1  clock; all state on rising edge.
- resetn  in  1  asynchronous active-low reset.
- data_sram_req  in  1  request valid.
- data_sram_wr  in  1  1 = write, 0 = read.
- data_sram_size  in  2  0 = byte, 1 = half, 2 = word; informational only.
- data_sram_wstrb  in  4  byte-lane write enables; used only when wr = 1.
- data_sram_addr  in  32  byte address.
- data_sram_wdata  in  32  write data.
- data_sram_addr_ok  out  1  request accepted this cycle when high together with req.
- data_sram_data_ok  out  1  response valid; exactly one per accepted request.
- data_sram_rdata  out  32  read data; 0 for write responses.

Behaviour:
- Reset (resetn low, asynchronous): queue empty; latency counter 0; addr_ok = 0; data_ok = 0; rdata = 0. Memory array is not reset.
- Accept = req && addr_ok.
- Word index = addr[AW+1:2]. Address bits above AW+1 are ignored, so addresses alias. addr[1:0] is ignored; byte placement is carried entirely by wstrb.
- Accepted write: the array word is updated at the accept edge, each byte lane only where its wstrb bit is set. wstrb = 0 is a legal no-op write that still returns data_ok.
- Accepted read: the array word is sampled at the accept edge and stored in the queue entry (read-at-accept).
- Consequences of read-at-accept:
  - A read accepted after a write to the same word returns the new data.
  - A write accepted after a read does not alter that read's returned data.
- addr_ok: high when (queue count < DEPTH) and (wait counter >= ADDR_LAT).
  - The wait counter increments each cycle req is high without accept.
  - It clears on accept or when req is low.
  - With ADDR_LAT = 0, addr_ok is combinational from queue state only.
- Queue: DEPTH-entry circular FIFO with head/tail pointers and a count.
  - Each entry holds {rdata, countdown}; countdown is loaded with DATA_LAT-1 at accept.
  - Every valid entry's countdown decrements each cycle, saturating at 0.
- data_ok = head valid && head countdown == 0, driven combinationally from the head entry; rdata = head rdata, else 0.
  - The head pops on that same edge.
  - Responses are strictly in acceptance order, at most one per cycle.
  - A request accepted at edge T produces data_ok no earlier than the cycle after edge T+DATA_LAT-1, i.e. DATA_LAT cycles after acceptance.
- There is no response backpressure: the consumer must take data_ok whenever it is asserted.
- Full: when count == DEPTH, addr_ok = 0, even if a pop occurs in the same cycle (no pass-through).
- Empty: data_ok = 0 and rdata = 0.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap modulo DEPTH.
- Protocol rules for the master, checked by assertions only:
  - Once req is raised it must be held, with stable wr/addr/wdata/wstrb/size, until addr_ok.
  - DATA_LAT < 1 is a parameter error and must be caught by an elaboration-time check.
- Reset asserted mid-operation: all queued responses are discarded and no data_ok is issued for them; memory retains its contents.

Test Plan:
- ADDR_LAT=0, DATA_LAT=1: write addr 0x1C0, wdata 0xDEADBEEF, wstrb 0xF, then read 0x1C0 -> data_ok one cycle after each accept; read returns 0xDEADBEEF; write response rdata = 0.
- Byte strobe: write 0x11223344 to 0x40, then write 0x000000AA with wstrb 0x1, then read 0x40 -> 0x112233AA.
- Back-to-back reads with DEPTH=2, DATA_LAT=3, req held high -> two accepts on consecutive cycles; addr_ok drops with 2 outstanding; data_ok returns in order; third accept occurs only after the first pop.
- ADDR_LAT=2: req rises at cycle 5 -> addr_ok high at cycle 7 only; wait counter clears after accept.
- Ordering: read 0x80 (old value 0x5), then write 0x9 to 0x80, both outstanding -> read response 0x5, write response next, subsequent read returns 0x9.
- Reset: drop resetn while 2 responses are pending -> data_ok, addr_ok and rdata go 0 immediately; after release no stale data_ok; earlier written data is still readable.
